// File: rtl/dmac_regs.sv
// dmac_regs: AHB-Lite zero-wait register block for a simple DMA controller.
//
// Purpose: holds the transfer descriptor (source/destination address, sizes,
// increments, block geometry, interrupt-clear address/data) programmed by
// software, launches the DMA engine with a one-cycle start pulse and keeps a
// sticky DONE flag that drives a level interrupt.
//
// Ports:
//   HCLK, HRESET            clock, asynchronous active-high reset
//   HSEL..HREADY            AHB-Lite slave inputs
//   HREADYOUT, HRDATA       AHB-Lite slave outputs (never stalls)
//   saddr, daddr            source / destination addresses
//   icr_addr, icr           interrupt-clear address / value
//   ssize, dsize, sinc,
//   dinc, irqsrc, wfi       CFG register fields
//   bsize, bcount           BLK register fields
//   start                   one-cycle launch pulse to the engine
//   done, busy              engine status inputs
//   irq                     level interrupt = DONE & IE
module dmac_regs (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [31:0] saddr,
  output logic [31:0] daddr,
  output logic [31:0] icr_addr,
  output logic [31:0] icr,
  output logic [2:0]  ssize,
  output logic [2:0]  dsize,
  output logic [2:0]  sinc,
  output logic [2:0]  dinc,
  output logic [2:0]  irqsrc,
  output logic [7:0]  bsize,
  output logic [7:0]  bcount,
  output logic        wfi,
  output logic        start,
  input  logic        done,
  input  logic        busy,
  output logic        irq
);

  // Implemented bits of CFG and BLK; everything else is stored and read as 0.
  localparam logic [31:0] CFG_MASK = 32'h0071_7777;
  localparam logic [31:0] BLK_MASK = 32'h0000_FFFF;

  logic        dp_valid;
  logic        dp_write;
  logic [2:0]  dp_size;
  logic [4:0]  dp_addr;
  logic [2:0]  dp_sel;
  logic [3:0]  be;
  logic [31:0] wmask;
  logic [31:0] reg_val;
  logic [31:0] merged;
  logic [31:0] cfg_q;
  logic [31:0] blk_q;
  logic        ie_q;
  logic        done_q;
  logic        wr_en;
  logic        locked;
  logic        go_ok;
  logic        w1c;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:5], HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign dp_sel    = dp_addr[4:2];

  // Address-phase capture. The latch only advances when the bus advances so a
  // stall in another slave's data phase cannot corrupt our pending transfer.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_size  <= 3'd0;
      dp_addr  <= 5'd0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_size  <= HSIZE;
      dp_addr  <= HADDR[4:0];
    end
  end

  // Byte-lane enables for the data phase, from latched size and low address.
  always_comb begin
    be = 4'b0000;
    case (dp_size)
      3'd0:    be[dp_addr[1:0]] = 1'b1;
      3'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  // Current contents of the addressed register; shared by the read path and
  // the partial-write merge.
  always_comb begin
    reg_val = 32'd0;
    case (dp_sel)
      3'd0: reg_val = saddr;
      3'd1: reg_val = daddr;
      3'd2: reg_val = cfg_q;
      3'd3: reg_val = blk_q;
      3'd4: reg_val = {30'd0, ie_q, 1'b0};
      3'd5: reg_val = {30'd0, done_q, busy | start};
      3'd6: reg_val = icr_addr;
      3'd7: reg_val = icr;
      default: reg_val = 32'd0;
    endcase
  end

  assign merged = (reg_val & ~wmask) | (HWDATA & wmask);
  assign HRDATA = (dp_valid & ~dp_write) ? reg_val : 32'd0;

  // Descriptor registers are frozen from the go pulse until the engine drops
  // busy; go and DONE-clear only see bit 0/1 of byte lane 0.
  assign wr_en  = dp_valid & dp_write & HREADY;
  assign locked = busy | start;
  assign go_ok  = wr_en & (dp_sel == 3'd4) & be[0] & HWDATA[0] & ~locked;
  assign w1c    = wr_en & (dp_sel == 3'd5) & be[0] & HWDATA[1];

  // Register file update. A done pulse from the engine beats any clear that
  // lands on the same edge, so a completion is never lost.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      saddr    <= 32'd0;
      daddr    <= 32'd0;
      cfg_q    <= 32'd0;
      blk_q    <= 32'd0;
      icr_addr <= 32'd0;
      icr      <= 32'd0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      start    <= 1'b0;
    end else begin
      if (wr_en && !locked) begin
        case (dp_sel)
          3'd0:    saddr    <= merged;
          3'd1:    daddr    <= merged;
          3'd2:    cfg_q    <= merged & CFG_MASK;
          3'd3:    blk_q    <= merged & BLK_MASK;
          3'd6:    icr_addr <= merged;
          3'd7:    icr      <= merged;
          default: ;
        endcase
      end
      if (wr_en && (dp_sel == 3'd4) && be[0]) begin
        ie_q <= HWDATA[1];
      end
      start <= go_ok;
      if (done) begin
        done_q <= 1'b1;
      end else if (w1c || go_ok) begin
        done_q <= 1'b0;
      end
    end
  end

  assign ssize  = cfg_q[2:0];
  assign dsize  = cfg_q[6:4];
  assign sinc   = cfg_q[10:8];
  assign dinc   = cfg_q[14:12];
  assign wfi    = cfg_q[16];
  assign irqsrc = cfg_q[22:20];
  assign bsize  = blk_q[7:0];
  assign bcount = blk_q[15:8];
  assign irq    = done_q & ie_q;

endmodule

// File: tb/tb_dmac_regs.sv
// Testbench for dmac_regs: directed register-map scenarios with literal
// expectations, then randomized AHB traffic checked every cycle against a
// transaction-level model of the register map.
module tb_dmac_regs;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        HSEL = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'd2;
   logic [31:0] HADDR = 32'd0;
   logic [31:0] HWDATA = 32'd0;
   logic        HREADY = 1'b1;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic [31:0] saddr, daddr, icrAddr, icr;
   logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
   logic [7:0]  bsize, bcount;
   logic        wfi, start, irq;
   logic        engDone = 1'b0;
   logic        engBusy = 1'b0;
   logic        pulseDone = 1'b0;

   int compared = 0;
   int mismatched = 0;

   dmac_regs dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
      .saddr(saddr), .daddr(daddr), .icr_addr(icrAddr), .icr(icr),
      .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc),
      .irqsrc(irqsrc), .bsize(bsize), .bcount(bcount), .wfi(wfi),
      .start(start), .done(engDone), .busy(engBusy), .irq(irq)
   );

   // 100 MHz clock
   always #5 HCLK = ~HCLK;

   // Reference model: register contents as plain words plus the pending
   // data-phase descriptor.
   logic [31:0] mRegs [8];
   logic        mIe, mDone, mStart, mPv, mPw;
   logic [2:0]  mSize;
   logic [4:0]  mAddr;
   logic [31:0] tMerged;
   logic [2:0]  tIdx;
   logic        tByte0, tLocked, tGo, tW1c;

   // Model update on each clock edge, derived from the register-map rules.
   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < 8; i++) mRegs[i] <= 32'd0;
         mIe <= 1'b0; mDone <= 1'b0; mStart <= 1'b0;
         mPv <= 1'b0; mPw <= 1'b0; mSize <= 3'd0; mAddr <= 5'd0;
      end else begin
         tGo = 1'b0;
         tW1c = 1'b0;
         if (mPv && mPw && HREADY) begin
            tIdx = mAddr[4:2];
            tMerged = mRegs[tIdx];
            for (int b = 0; b < 4; b++) begin
               if (mSize >= 3'd2 || (mSize == 3'd1 && b[1] == mAddr[1]) ||
                   (mSize == 3'd0 && b[1:0] == mAddr[1:0]))
                  tMerged[8*b +: 8] = HWDATA[8*b +: 8];
            end
            tByte0 = (mSize >= 3'd2) || (mSize == 3'd1 && !mAddr[1]) ||
                     (mSize == 3'd0 && mAddr[1:0] == 2'd0);
            tLocked = engBusy || mStart;
            if (tIdx == 3'd2) tMerged = tMerged & 32'h0071_7777;
            if (tIdx == 3'd3) tMerged = tMerged & 32'h0000_FFFF;
            if (tIdx != 3'd4 && tIdx != 3'd5 && !tLocked) mRegs[tIdx] <= tMerged;
            if (tIdx == 3'd4 && tByte0) begin
               mIe <= HWDATA[1];
               tGo = HWDATA[0] && !tLocked;
            end
            if (tIdx == 3'd5 && tByte0 && HWDATA[1]) tW1c = 1'b1;
         end
         mStart <= tGo;
         if (engDone) mDone <= 1'b1;
         else if (tW1c || tGo) mDone <= 1'b0;
         if (HREADY) begin
            mPv <= HSEL && HTRANS[1];
            mPw <= HWRITE;
            mSize <= HSIZE;
            mAddr <= HADDR[4:0];
         end
      end
   end

   function automatic logic [31:0] expRead();
      logic [31:0] v;
      v = 32'd0;
      if (mPv && !mPw) begin
         case (mAddr[4:2])
            3'd4: v = {30'd0, mIe, 1'b0};
            3'd5: v = {30'd0, mDone, engBusy || mStart};
            default: v = mRegs[mAddr[4:2]];
         endcase
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle out of reset, DUT outputs against the model.
   always @(negedge HCLK) begin
      if (!HRESET) begin
         checkOutput("hrdata", {32'd0, HRDATA}, {32'd0, expRead()});
         checkOutput("hreadyout", {63'd0, HREADYOUT}, 64'd1);
         checkOutput("saddr_daddr", {saddr, daddr}, {mRegs[0], mRegs[1]});
         checkOutput("icr", {icrAddr, icr}, {mRegs[6], mRegs[7]});
         checkOutput("cfg", {49'd0, ssize, dsize, sinc, dinc, wfi, irqsrc},
                     {49'd0, mRegs[2][2:0], mRegs[2][6:4], mRegs[2][10:8],
                      mRegs[2][14:12], mRegs[2][16], mRegs[2][22:20]});
         checkOutput("blk", {48'd0, bcount, bsize}, {48'd0, mRegs[3][15:0]});
         checkOutput("start_irq", {62'd0, start, irq}, {62'd0, mStart, mDone && mIe});
      end
   end

   // One bus cycle: address phase of a new transfer plus HWDATA for the
   // previous one. pulseDone raises the engine's done for this cycle only.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [2:0] sz,
                                input logic v, input logic [31:0] wd);
      @(posedge HCLK);
      #1;
      HSEL = v;
      HTRANS = v ? 2'b10 : 2'b00;
      HWRITE = w;
      HSIZE = sz;
      HADDR = a;
      HWDATA = wd;
      HREADY = 1'b1;
      engDone = pulseDone;
      pulseDone = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 32'd0, 3'd2, 1'b0, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b0;
      @(negedge HCLK);
      checkOutput("lit_reset_hrdata", {32'd0, HRDATA}, 64'd0);
      checkOutput("lit_reset_start_irq", {62'd0, start, irq}, 64'd0);
      checkOutput("lit_reset_saddr", {32'd0, saddr}, 64'd0);

      // SADDR write then read back.
      applyStimulus(1'b1, 32'h0, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b0, 32'h0, 3'd2, 1'b1, 32'h2000_0000);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_saddr_read", {32'd0, HRDATA}, 64'h2000_0000);
      checkOutput("lit_saddr_out", {32'd0, saddr}, 64'h2000_0000);

      // BLK word write then byte write to lane 1.
      applyStimulus(1'b1, 32'hC, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b1, 32'hD, 3'd0, 1'b1, 32'h0000_1020);
      applyStimulus(1'b0, 32'hC, 3'd2, 1'b1, 32'h0000_AB00);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_blk_read", {32'd0, HRDATA}, 64'h0000_AB20);
      checkOutput("lit_blk_fields", {48'd0, bcount, bsize}, 64'hAB20);

      // go with busy low: exactly one start cycle.
      applyStimulus(1'b1, 32'h10, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b0, 32'h0, 3'd2, 1'b0, 32'h3);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_start_pulse", {63'd0, start}, 64'd1);
      engBusy = 1'b1;
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_start_end", {63'd0, start}, 64'd0);
      // go while busy: no pulse.
      applyStimulus(1'b1, 32'h10, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b0, 32'h0, 3'd2, 1'b0, 32'h3);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_go_busy", {63'd0, start}, 64'd0);
      // CFG write while busy is dropped.
      applyStimulus(1'b1, 32'h8, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b0, 32'h8, 3'd2, 1'b1, 32'h0000_0007);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_cfg_locked", {32'd0, HRDATA}, 64'd0);
      engBusy = 1'b0;

      // done pulse with ie=1, then W1C, then W1C coincident with done.
      pulseDone = 1'b1;
      idleCycle();
      applyStimulus(1'b0, 32'h14, 3'd2, 1'b1, 32'd0);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_status_done", {32'd0, HRDATA}, 64'h2);
      checkOutput("lit_irq_set", {63'd0, irq}, 64'd1);
      applyStimulus(1'b1, 32'h14, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b0, 32'h0, 3'd2, 1'b0, 32'h2);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_irq_cleared", {63'd0, irq}, 64'd0);
      pulseDone = 1'b1;
      idleCycle();
      idleCycle();
      applyStimulus(1'b1, 32'h14, 3'd2, 1'b1, 32'd0);
      pulseDone = 1'b1;
      applyStimulus(1'b0, 32'h0, 3'd2, 1'b0, 32'h2);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_done_beats_w1c", {63'd0, irq}, 64'd1);

      // Reset during a SADDR data phase: nothing commits afterwards.
      applyStimulus(1'b1, 32'h0, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b0, 32'h0, 3'd2, 1'b0, 32'h1234_5678);
      #2 HRESET = 1'b1;
      @(posedge HCLK);
      #1 HRESET = 1'b0;
      idleCycle();
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_reset_discard", {32'd0, saddr}, 64'd0);

      // Back-to-back DADDR write then read.
      applyStimulus(1'b1, 32'h4, 3'd2, 1'b1, 32'd0);
      applyStimulus(1'b0, 32'h4, 3'd2, 1'b1, 32'hCAFE_F00D);
      idleCycle();
      @(negedge HCLK);
      checkOutput("lit_b2b_read", {32'd0, HRDATA}, 64'hCAFE_F00D);
      checkOutput("lit_b2b_ready", {63'd0, HREADYOUT}, 64'd1);

      // Randomized traffic, checked by the compare process each cycle.
      for (int n = 0; n < 3000; n++) begin
         @(posedge HCLK);
         #1;
         HSEL = ($urandom_range(0, 4) != 0);
         HTRANS = 2'($urandom_range(0, 3));
         HWRITE = 1'($urandom_range(0, 1));
         HSIZE = 3'($urandom_range(0, 2));
         HADDR = $urandom;
         HWDATA = $urandom;
         HREADY = ($urandom_range(0, 9) != 0);
         engDone = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0) engBusy = ~engBusy;
         if ($urandom_range(0, 499) == 0) begin
            HRESET = 1'b1;
            @(posedge HCLK);
            #1 HRESET = 1'b0;
         end
      end

      idleCycle();
      @(negedge HCLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #2ms;
      mismatched++;
      $display("[TB] FAIL timeout: got no completion expected finish before 2ms");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/dmac_regs.md
DMAC_REGS -- requirements
Module: dmac_regs

Interface
REQ-001 Parameter: none; register map fixed by REQ-012.
REQ-002 HCLK  in  1  single clock; all state changes on rising edge.
REQ-003 HRESET  in  1  asynchronous, active-high reset.
REQ-004 HSEL, HTRANS[1:0], HWRITE, HSIZE[2:0], HADDR[31:0], HWDATA[31:0], HREADY  in  AHB-Lite slave inputs.
REQ-005 HREADYOUT  out  1  always 1 (zero-wait slave); HRDATA  out  32  read data.
REQ-006 saddr, daddr, icr_addr, icr  out  32 each  programmed values to the DMA engine.
REQ-007 ssize, dsize, sinc, dinc, irqsrc  out  3 each; bsize, bcount  out  8 each; wfi  out  1.
REQ-008 start  out  1  one-cycle launch pulse to the DMA engine.
REQ-009 done, busy  in  1 each  from the DMA engine (done: one-cycle completion indication).
REQ-010 irq  out  1  level interrupt, = DONE flag AND IE.

Function
REQ-011 Address phase SHALL be captured when HSEL & HTRANS[1] & HREADY; the latched address, HWRITE and HSIZE are used in the following data phase.
REQ-012 Map (HADDR[4:2]): 0 SADDR; 1 DADDR; 2 CFG {ssize[2:0], dsize[6:4], sinc[10:8], dinc[14:12], wfi[16], irqsrc[22:20]}; 3 BLK {bsize[7:0], bcount[15:8]}; 4 CTRL {go[0] WO, ie[1] RW}; 5 STATUS {busy[0] RO, done[1] W1C}; 6 ICRADDR; 7 ICR.
REQ-013 Writes SHALL commit at the end of the data phase using HWDATA; byte/halfword writes (HSIZE 0/1) update only the lanes selected by latched HADDR[1:0]; reserved CFG/BLK bits read 0.
REQ-014 HRDATA SHALL be combinational from the latched data-phase address; reads of any location in the cycle after a write's data phase return the new value.
REQ-015 Writes to SADDR, DADDR, CFG, BLK, ICRADDR, ICR SHALL be ignored while busy=1 or start=1; CTRL.ie and STATUS W1C remain writable.
REQ-016 Writing 1 to CTRL.go while busy=0 and start=0 SHALL assert start for exactly one cycle, starting the cycle after the data phase, and SHALL clear DONE in the same edge.
REQ-017 Writing CTRL.go while busy=1 or start=1 SHALL be ignored (no pulse); CTRL.go reads 0.
REQ-018 DONE flag SHALL set on the edge where done=1; setting wins over a simultaneous W1C write.
REQ-019 STATUS.busy SHALL read busy OR start, so software never observes idle between go and engine acknowledge.
REQ-020 irq SHALL be registered-flag derived (no combinational path from AHB inputs).
REQ-021 Non-selected or IDLE/BUSY transfers SHALL cause no register change; HRDATA outside a valid read data phase = 0.
REQ-022 Two back-to-back transfers (pipelined address/data) SHALL each complete in one cycle without corruption.

Reset
REQ-023 On HRESET: all registers 0, start=0, irq=0, HREADYOUT=1, HRDATA=0, latched transfer invalid.
REQ-024 Reset asserted mid-transfer SHALL discard the pending data phase; no write commits after release.
REQ-025 First transfer accepted on the first HCLK edge after HRESET deasserts.

Verification
REQ-026 Write 0x2000_0000 to SADDR, read back -> HRDATA=0x2000_0000 and saddr=0x2000_0000 in the cycle after the write data phase.
REQ-027 Byte write 0xAB to HADDR 0x0D (BLK, lane 1) with BLK=0x0000_1020 -> BLK=0x0000_AB20, bcount=0xAB, bsize=0x20.
REQ-028 Write CTRL=0x3 with busy=0 -> start high exactly 1 cycle; second go while busy=1 -> no pulse; CFG write during busy -> unchanged.
REQ-029 Pulse done=1 with ie=1 -> STATUS=0x2, irq=1; write STATUS=0x2 -> irq=0; W1C coincident with done -> DONE stays 1.
REQ-030 Assert HRESET during a SADDR write data phase -> saddr=0 after release, no late commit.
REQ-031 Back-to-back write DADDR then read DADDR -> read returns written value, HREADYOUT=1 throughout.
